// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 store path: access-size codes,
// store FSM state encoding and datapath widths.
package msrv32_pkg;

    localparam int XLEN   = 32;
    localparam int MASK_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/msrv32_store_align.sv
// Combinational lane steering for stores: word address, replicated data, byte mask,
// and the accept decision that folds in misalignment when TRAP_EN is set.
module msrv32_store_align
    import msrv32_pkg::*;
#(
    parameter bit TRAP_EN = 1'b0
) (
    input  logic              store_req,
    input  logic [1:0]        load_size,
    input  logic [XLEN-1:0]   iadder,
    input  logic [XLEN-1:0]   rs2,
    output logic [XLEN-1:0]   addr,
    output logic [XLEN-1:0]   data,
    output logic [MASK_W-1:0] mask,
    output logic              accept
);

    logic misaligned_s;

    // Size-dependent replication and mask; words ignore the low address bits
    always_comb begin
        addr         = {iadder[XLEN-1:2], 2'b00};
        data         = rs2;
        mask         = 4'b1111;
        misaligned_s = 1'b0;
        case (load_size)
            SZ_BYTE: begin
                data         = {4{rs2[7:0]}};
                mask         = 4'b0001 << iadder[1:0];
                misaligned_s = 1'b0;
            end
            SZ_HALF: begin
                data         = {2{rs2[15:0]}};
                mask         = iadder[1] ? 4'b1100 : 4'b0011;
                misaligned_s = iadder[0];
            end
            default: begin
                data         = rs2;
                mask         = 4'b1111;
                misaligned_s = |iadder[1:0];
            end
        endcase
        accept = store_req & ~(TRAP_EN & misaligned_s);
    end

endmodule

// File: rtl/msrv32_store_unit_hs.sv
// Handshaked store unit: captures one store, holds the write request until ack
// or MAX_WAIT-cycle timeout. Optional misalignment trap: MSRV32_MISALIGN_TRAP_EN.
module msrv32_store_unit_hs
    import msrv32_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              store_req_in,
    input  logic [1:0]        load_size_in,
    input  logic [XLEN-1:0]   iadder_in,
    input  logic [XLEN-1:0]   rs2_in,
    input  logic              dm_ack_in,
    output logic [XLEN-1:0]   dm_addr_out,
    output logic [XLEN-1:0]   dm_data_out,
    output logic [MASK_W-1:0] dm_wr_mask_out,
    output logic              dm_wr_req_out,
    output logic              stall_out,
    output logic              store_done_out,
    output logic              bus_err_out
`ifdef MSRV32_MISALIGN_TRAP_EN
    ,
    output logic              misaligned_store_out
`endif
);

`ifdef MSRV32_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t            state_r;
    logic [7:0]        wait_cnt_r;
    logic [XLEN-1:0]   addr_s;
    logic [XLEN-1:0]   data_s;
    logic [MASK_W-1:0] mask_s;
    logic              accept_s;

    msrv32_store_align #(
        .TRAP_EN   (TRAP_EN)
    ) u_align (
        .store_req (store_req_in),
        .load_size (load_size_in),
        .iadder    (iadder_in),
        .rs2       (rs2_in),
        .addr      (addr_s),
        .data      (data_s),
        .mask      (mask_s),
        .accept    (accept_s)
    );

    // Stall is combinational so the pipeline freezes in the same cycle
    always_comb begin
        stall_out = ((state_r == ST_IDLE) & accept_s) | ((state_r == ST_REQ) & ~dm_ack_in);
    end

    // Store FSM, wait counter, captured write beat and pulse outputs
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_r              <= ST_IDLE;
            wait_cnt_r           <= 8'd0;
            dm_addr_out          <= 32'd0;
            dm_data_out          <= 32'd0;
            dm_wr_mask_out       <= 4'd0;
            dm_wr_req_out        <= 1'b0;
            store_done_out       <= 1'b0;
            bus_err_out          <= 1'b0;
`ifdef MSRV32_MISALIGN_TRAP_EN
            misaligned_store_out <= 1'b0;
`endif
        end else begin
            store_done_out       <= 1'b0;
            bus_err_out          <= 1'b0;
`ifdef MSRV32_MISALIGN_TRAP_EN
            misaligned_store_out <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
`ifdef MSRV32_MISALIGN_TRAP_EN
                    misaligned_store_out <= store_req_in & ~accept_s;
`endif
                    if (accept_s) begin
                        state_r        <= ST_REQ;
                        wait_cnt_r     <= 8'd0;
                        dm_addr_out    <= addr_s;
                        dm_data_out    <= data_s;
                        dm_wr_mask_out <= mask_s;
                        dm_wr_req_out  <= 1'b1;
                    end else begin
                        dm_wr_req_out  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a coincident timeout
                    if (dm_ack_in) begin
                        state_r        <= ST_IDLE;
                        dm_wr_req_out  <= 1'b0;
                        store_done_out <= 1'b1;
                    end else if (wait_cnt_r == LAST_WAIT) begin
                        state_r        <= ST_IDLE;
                        dm_wr_req_out  <= 1'b0;
                        bus_err_out    <= 1'b1;
                    end else begin
                        wait_cnt_r     <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    wait_cnt_r    <= 8'd0;
                    dm_wr_req_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_store_unit_hs.sv
// Self-checking bench for msrv32_store_unit_hs (MAX_WAIT=4) against a
// transaction-level reference model of the store handshake.
module tb_msrv32_store_unit_hs;

    localparam int MW = 4;
`ifdef MSRV32_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        store_req_in;
    logic [1:0]  load_size_in;
    logic [31:0] iadder_in;
    logic [31:0] rs2_in;
    logic        dm_ack_in;
    logic [31:0] dm_addr_out;
    logic [31:0] dm_data_out;
    logic [3:0]  dm_wr_mask_out;
    logic        dm_wr_req_out;
    logic        stall_out;
    logic        store_done_out;
    logic        bus_err_out;
`ifdef MSRV32_MISALIGN_TRAP_EN
    logic        misaligned_store_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    msrv32_store_unit_hs #(.MAX_WAIT(MW)) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .store_req_in   (store_req_in),
        .load_size_in   (load_size_in),
        .iadder_in      (iadder_in),
        .rs2_in         (rs2_in),
        .dm_ack_in      (dm_ack_in),
        .dm_addr_out    (dm_addr_out),
        .dm_data_out    (dm_data_out),
        .dm_wr_mask_out (dm_wr_mask_out),
        .dm_wr_req_out  (dm_wr_req_out),
        .stall_out      (stall_out),
        .store_done_out (store_done_out),
        .bus_err_out    (bus_err_out)
`ifdef MSRV32_MISALIGN_TRAP_EN
        ,
        .misaligned_store_out (misaligned_store_out)
`endif
    );

    function automatic logic [3:0] ref_mask(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << (a % 4));
        if (sz == 2'd1) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_data(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'd255) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'd65535) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic misaligned_seen();
`ifdef MSRV32_MISALIGN_TRAP_EN
        return misaligned_store_out;
`else
        return 1'b0;
`endif
    endfunction

    // One store transaction; delay = REQ cycle index of ack, negative = never ack.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                             input int delay, input string tag);
        bit trap = TRAP && ref_mis(sz, a);
        logic [31:0] ea = (a / 4) * 4;
        logic [31:0] ed = ref_data(sz, d);
        logic [3:0]  em = ref_mask(sz, a);
        int stalls = 0;
        int exp_stalls;
        int k = 0;
        bit fin = 1'b0;
        bit acked = 1'b0;
        store_req_in = 1'b1; load_size_in = sz; iadder_in = a; rs2_in = d; dm_ack_in = 1'b0;
        #1;
        checks++;
        if (stall_out !== !trap) begin
            errors++; $display("FAIL %s accept_stall got %b want %b", tag, stall_out, !trap);
        end
        if (stall_out) stalls++;
        @(posedge clk_in); #1;
        if (trap) begin
            store_req_in = 1'b0;
            checks++;
            if (dm_wr_req_out !== 1'b0 || misaligned_seen() !== 1'b1 || stall_out !== 1'b0) begin
                errors++; $display("FAIL %s trap req=%b mis=%b stall=%b want 0 1 0", tag,
                                   dm_wr_req_out, misaligned_seen(), stall_out);
            end
            @(posedge clk_in); #1;
            checks++;
            if (misaligned_seen() !== 1'b0 || dm_wr_req_out !== 1'b0) begin
                errors++; $display("FAIL %s trap_pulse mis=%b req=%b want 0 0", tag,
                                   misaligned_seen(), dm_wr_req_out);
            end
            return;
        end
        while (!fin) begin
            // Noise on the request inputs must be ignored while busy
            store_req_in = 1'($urandom); load_size_in = 2'($urandom);
            iadder_in = $urandom; rs2_in = $urandom;
            checks++;
            if (dm_wr_req_out !== 1'b1 || dm_addr_out !== ea || dm_data_out !== ed ||
                dm_wr_mask_out !== em || store_done_out !== 1'b0 || bus_err_out !== 1'b0) begin
                errors++; $display("FAIL %s req_cyc%0d req=%b addr=%h data=%h mask=%b done=%b err=%b want 1 %h %h %b 0 0",
                                   tag, k, dm_wr_req_out, dm_addr_out, dm_data_out, dm_wr_mask_out,
                                   store_done_out, bus_err_out, ea, ed, em);
            end
            dm_ack_in = (k == delay);
            #1;
            checks++;
            if (stall_out !== !dm_ack_in) begin
                errors++; $display("FAIL %s req_stall%0d got %b want %b", tag, k, stall_out, !dm_ack_in);
            end
            if (stall_out) stalls++;
            acked = dm_ack_in;
            fin = acked || (k == MW - 1);
            @(posedge clk_in); #1;
            k++;
        end
        store_req_in = 1'b0; dm_ack_in = 1'b0;
        checks++;
        if (dm_wr_req_out !== 1'b0 || store_done_out !== acked || bus_err_out !== !acked) begin
            errors++; $display("FAIL %s exit req=%b done=%b err=%b want 0 %b %b", tag,
                               dm_wr_req_out, store_done_out, bus_err_out, acked, !acked);
        end
        @(posedge clk_in); #1;
        checks++;
        if (dm_wr_req_out !== 1'b0 || store_done_out !== 1'b0 || bus_err_out !== 1'b0) begin
            errors++; $display("FAIL %s pulse_end req=%b done=%b err=%b want 0 0 0", tag,
                               dm_wr_req_out, store_done_out, bus_err_out);
        end
        exp_stalls = (delay >= 0 && delay < MW) ? delay + 1 : MW + 1;
        checks++;
        if (stalls != exp_stalls) begin
            errors++; $display("FAIL %s stall_cycles got %0d want %0d", tag, stalls, exp_stalls);
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1; store_req_in = 1'b0; load_size_in = 2'd0;
        iadder_in = 32'd0; rs2_in = 32'd0; dm_ack_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (dm_addr_out !== 32'd0 || dm_data_out !== 32'd0 || dm_wr_mask_out !== 4'd0 ||
            dm_wr_req_out !== 1'b0 || store_done_out !== 1'b0 || bus_err_out !== 1'b0 ||
            stall_out !== 1'b0 || misaligned_seen() !== 1'b0) begin
            errors++; $display("FAIL reset_state addr=%h data=%h mask=%b req=%b done=%b err=%b stall=%b want all 0",
                               dm_addr_out, dm_data_out, dm_wr_mask_out, dm_wr_req_out,
                               store_done_out, bus_err_out, stall_out);
        end
        reset_in = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic test_directed();
        run_store(2'b00, 32'h0000_1003, 32'h0000_00A5, 0, "byte_1003");
        run_store(2'b01, 32'h0000_2002, 32'h1234_BEEF, 2, "half_2002");
        run_store(2'b10, 32'h0000_3001, 32'hCAFE_F00D, 0, "word_3001");
        run_store(2'b10, 32'h0000_4000, 32'h0BAD_BEEF, MW - 1, "ack_at_timeout");
    endtask

    task automatic test_timeout();
        run_store(2'b10, 32'h0000_5004, 32'h1111_2222, -1, "timeout");
    endtask

    task automatic test_random_stores();
        for (int n = 0; n < 40; n++) begin
            int dl = int'($urandom_range(0, MW + 1));
            if (dl >= MW) dl = -1;
            run_store(2'($urandom), $urandom, $urandom, dl, "random");
        end
    endtask

    task automatic test_reset_in_req();
        store_req_in = 1'b1; load_size_in = 2'b10; iadder_in = 32'h0000_6000;
        rs2_in = 32'hDEAD_BEEF; dm_ack_in = 1'b0;
        @(posedge clk_in); #1;
        store_req_in = 1'b0;
        @(posedge clk_in); #2;
        reset_in = 1'b1;
        #1;
        checks++;
        if (dm_addr_out !== 32'd0 || dm_data_out !== 32'd0 || dm_wr_mask_out !== 4'd0 ||
            dm_wr_req_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL async_reset addr=%h data=%h mask=%b req=%b stall=%b want all 0",
                               dm_addr_out, dm_data_out, dm_wr_mask_out, dm_wr_req_out, stall_out);
        end
        @(negedge clk_in);
        reset_in = 1'b0;
        for (int c = 0; c < MW + 2; c++) begin
            @(posedge clk_in); #1;
            checks++;
            if (dm_wr_req_out !== 1'b0 || store_done_out !== 1'b0 || bus_err_out !== 1'b0) begin
                errors++; $display("FAIL post_reset%0d req=%b done=%b err=%b want 0 0 0", c,
                                   dm_wr_req_out, store_done_out, bus_err_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_random_stores();
        test_reset_in_req();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
